// File: rtl/inst_fetch.sv
// Instruction fetch stage: requests one word per instruction, holds it in IR for
// decode, and computes the next PC from a one-hot select when decode advances.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter logic [31:0] EXC_VEC  = 32'hBFC00380,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  ctl_pcValue_mux,
    input  logic [31:0] rs_value,
    input  logic        advance,
    output logic        ctl_instRam_en,
    output logic        ctl_instRam_wen,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_rdata,
    input  logic        inst_rvalid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [31:0] pc,
    output logic        ir_valid,
    output logic        fetch_timeout,
    output logic        sel_err,
    output logic [1:0]  dbg_state
);

    // Handshake: a request is one cycle of ctl_instRam_en with inst_addr valid;
    // the RAM answers with a single inst_rvalid pulse one or more cycles later.
    // Decode consumes the instruction by pulsing advance while ir_valid is high.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_ir_valid;
    logic        r_sel_err;
    logic        r_fetch_timeout;
    logic [7:0]  r_wait_cnt;
    logic        r_resetn_q;

    logic        w_wait_hit;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_tgt;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_sel_pc;
    logic        w_sel_onehot;
    logic [31:0] w_next_pc;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_branch_tgt = w_pc_plus4 + {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
    assign w_jump_tgt   = {w_pc_plus4[31:28], r_ir[25:0], 2'b00};
    assign w_wait_hit   = ({1'b0, r_wait_cnt} + 9'd1) >= {1'b0, TIMEOUT};

    always_comb begin
        w_sel_pc     = w_pc_plus4;
        w_sel_onehot = 1'b1;
        case (ctl_pcValue_mux)
            5'b00001: w_sel_pc = w_pc_plus4;
            5'b00010: w_sel_pc = w_branch_tgt;
            5'b00100: w_sel_pc = w_jump_tgt;
            5'b01000: w_sel_pc = rs_value;
            5'b10000: w_sel_pc = EXC_VEC;
            default: begin
                w_sel_pc     = w_pc_plus4;
                w_sel_onehot = 1'b0;
            end
        endcase
        // A legally selected but misaligned target traps to the exception vector.
        w_next_pc = w_sel_pc;
        if (w_sel_onehot && (w_sel_pc[1:0] != 2'b00)) begin
            w_next_pc = EXC_VEC;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            // Hold off the first request until reset has been released for a cycle.
            S_REQ:  if (r_resetn_q) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (inst_rvalid) begin
                    w_state_nxt = S_HOLD;
                end else if (w_wait_hit) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_HOLD: if (advance) w_state_nxt = S_REQ;
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        r_resetn_q <= resetn;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state         <= S_REQ;
            r_pc            <= RESET_PC;
            r_ir            <= 32'd0;
            r_ir_valid      <= 1'b0;
            r_sel_err       <= 1'b0;
            r_fetch_timeout <= 1'b0;
            r_wait_cnt      <= 8'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_fetch_timeout <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (inst_rvalid) begin
                        r_ir       <= inst_rdata;
                        r_ir_valid <= 1'b1;
                        r_wait_cnt <= 8'd0;
                    end else if (w_wait_hit) begin
                        r_wait_cnt      <= 8'd0;
                        r_fetch_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (advance) begin
                        r_pc       <= w_next_pc;
                        r_ir_valid <= 1'b0;
                        if (!w_sel_onehot) begin
                            r_sel_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ctl_instRam_en  = (r_state == S_REQ) && r_resetn_q;
    assign ctl_instRam_wen = 1'b0;
    assign inst_addr       = r_pc;
    assign opcode          = r_ir[31:26];
    assign rs              = r_ir[25:21];
    assign rt              = r_ir[20:16];
    assign rd              = r_ir[15:11];
    assign funct           = r_ir[5:0];
    assign imm             = r_ir[15:0];
    assign pc              = r_pc;
    assign ir_valid        = r_ir_valid;
    assign fetch_timeout   = r_fetch_timeout;
    assign sel_err         = r_sel_err;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: boot fetch, next-PC selection, illegal select,
// ignored advance/rvalid, fetch timeout and reset in the middle of a fetch.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  ctl_pcValue_mux;
    logic [31:0] rs_value;
    logic        advance;
    logic        ctl_instRam_en;
    logic        ctl_instRam_wen;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_rvalid;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] pc;
    logic        ir_valid;
    logic        fetch_timeout;
    logic        sel_err;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    inst_fetch dut (
        .clk             (clk),
        .resetn          (resetn),
        .ctl_pcValue_mux (ctl_pcValue_mux),
        .rs_value        (rs_value),
        .advance         (advance),
        .ctl_instRam_en  (ctl_instRam_en),
        .ctl_instRam_wen (ctl_instRam_wen),
        .inst_addr       (inst_addr),
        .inst_rdata      (inst_rdata),
        .inst_rvalid     (inst_rvalid),
        .opcode          (opcode),
        .rs              (rs),
        .rt              (rt),
        .rd              (rd),
        .funct           (funct),
        .imm             (imm),
        .pc              (pc),
        .ir_valid        (ir_valid),
        .fetch_timeout   (fetch_timeout),
        .sel_err         (sel_err),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; waits (bounded) for a request and checks its address.
    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        int n = 0;
        while (ctl_instRam_en !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_req_seen"}, {31'd0, ctl_instRam_en}, 32'd1);
        check_eq({tag, "_addr"}, inst_addr, exp_addr);
    endtask

    task automatic respond(input logic [31:0] data, input int lat);
        repeat (lat) @(negedge clk);
        inst_rvalid = 1'b1;
        inst_rdata  = data;
        @(negedge clk);
        inst_rvalid = 1'b0;
        inst_rdata  = 32'd0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] exp_addr,
                         input logic [31:0] data, input int lat);
        wait_req(tag, exp_addr);
        respond(data, lat);
        check_eq({tag, "_ir_valid"}, {31'd0, ir_valid}, 32'd1);
        check_eq({tag, "_pc"}, pc, exp_addr);
    endtask

    task automatic do_advance(input logic [4:0] sel, input logic [31:0] rsv);
        ctl_pcValue_mux = sel;
        rs_value        = rsv;
        advance         = 1'b1;
        @(negedge clk);
        advance         = 1'b0;
        ctl_pcValue_mux = 5'd0;
        rs_value        = 32'd0;
    endtask

    initial begin
        int n;
        resetn          = 1'b0;
        ctl_pcValue_mux = 5'd0;
        rs_value        = 32'd0;
        advance         = 1'b0;
        inst_rdata      = 32'd0;
        inst_rvalid     = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_en", {31'd0, ctl_instRam_en}, 32'd0);
        check_eq("rst_wen", {31'd0, ctl_instRam_wen}, 32'd0);
        check_eq("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check_eq("rst_pc", pc, 32'hBFC00000);
        check_eq("rst_sel_err", {31'd0, sel_err}, 32'd0);
        check_eq("rst_timeout", {31'd0, fetch_timeout}, 32'd0);
        check_eq("rst_opcode", 32'(opcode), 32'd0);

        // Boot fetch with one-cycle RAM latency.
        resetn = 1'b1;
        @(negedge clk);
        wait_req("boot", 32'hBFC00000);
        @(negedge clk);
        check_eq("boot_en_one_cycle", {31'd0, ctl_instRam_en}, 32'd0);
        check_eq("boot_ir_valid_c1", {31'd0, ir_valid}, 32'd0);
        inst_rvalid = 1'b1;
        inst_rdata  = 32'h3C081234;
        @(negedge clk);
        inst_rvalid = 1'b0;
        inst_rdata  = 32'd0;
        check_eq("boot_ir_valid_c2", {31'd0, ir_valid}, 32'd1);
        check_eq("boot_opcode", 32'(opcode), 32'h0F);
        check_eq("boot_rt", 32'(rt), 32'd8);
        check_eq("boot_imm", 32'(imm), 32'h1234);

        // Illegal select: two bits set falls back to PC+4 and sets sticky error.
        do_advance(5'b00110, 32'd0);
        check_eq("illegal_adv_to_req", {31'd0, ctl_instRam_en}, 32'd1);
        check_eq("illegal_ir_valid_clr", {31'd0, ir_valid}, 32'd0);
        check_eq("illegal_sel_err", {31'd0, sel_err}, 32'd1);

        fetch("f04", 32'hBFC00004, 32'h10000002, 2);
        do_advance(5'b00010, 32'd0);
        fetch("f10a", 32'hBFC00010, 32'h1000FFFC, 1);
        check_eq("f10a_imm", 32'(imm), 32'hFFFC);
        do_advance(5'b00010, 32'd0);
        fetch("br_back", 32'hBFC00004, 32'h10000002, 3);
        do_advance(5'b00010, 32'd0);
        fetch("f10b", 32'hBFC00010, 32'h10000003, 1);
        do_advance(5'b00010, 32'd0);
        fetch("br_fwd", 32'hBFC00020, 32'h08000100, 1);
        check_eq("br_fwd_opcode", 32'(opcode), 32'h02);
        do_advance(5'b00100, 32'd0);
        fetch("jump", 32'hB0000400, 32'h00000000, 1);
        do_advance(5'b01000, 32'h80000002);
        fetch("reg_misalign", 32'hBFC00380, 32'h00000000, 1);
        check_eq("sel_err_sticky", {31'd0, sel_err}, 32'd1);
        do_advance(5'b01000, 32'h80001000);
        fetch("reg_ok", 32'h80001000, 32'h00000000, 1);
        do_advance(5'b10000, 32'd0);
        fetch("exc", 32'hBFC00380, 32'h00000000, 1);
        do_advance(5'b00000, 32'd0);

        // Advance in REQ and WAIT is ignored; rvalid in HOLD is ignored.
        wait_req("ign", 32'hBFC00384);
        advance         = 1'b1;
        ctl_pcValue_mux = 5'b10000;
        @(negedge clk);
        @(negedge clk);
        advance         = 1'b0;
        ctl_pcValue_mux = 5'd0;
        inst_rvalid     = 1'b1;
        inst_rdata      = 32'h3C081234;
        @(negedge clk);
        check_eq("ign_adv_pc", pc, 32'hBFC00384);
        check_eq("ign_ir_valid", {31'd0, ir_valid}, 32'd1);
        inst_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        inst_rvalid = 1'b0;
        inst_rdata  = 32'd0;
        @(negedge clk);
        check_eq("hold_opcode", 32'(opcode), 32'h0F);
        check_eq("hold_imm", 32'(imm), 32'h1234);
        do_advance(5'b00001, 32'd0);

        // Timeout: no response for TIMEOUT wait cycles, then re-request.
        wait_req("to", 32'hBFC00388);
        n = 0;
        while (fetch_timeout !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("to_cycles", n, 32'd256);
        check_eq("to_rereq_en", {31'd0, ctl_instRam_en}, 32'd1);
        check_eq("to_rereq_addr", inst_addr, 32'hBFC00388);
        @(negedge clk);
        check_eq("to_pulse_clr", {31'd0, fetch_timeout}, 32'd0);

        // Reset in WAIT, with a late rvalid right after release.
        resetn = 1'b0;
        @(negedge clk);
        check_eq("wrst_pc", pc, 32'hBFC00000);
        check_eq("wrst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check_eq("wrst_sel_err", {31'd0, sel_err}, 32'd0);
        check_eq("wrst_en", {31'd0, ctl_instRam_en}, 32'd0);
        resetn      = 1'b1;
        inst_rvalid = 1'b1;
        inst_rdata  = 32'hAAAAAAAA;
        @(negedge clk);
        inst_rvalid = 1'b0;
        inst_rdata  = 32'd0;
        check_eq("late_rvalid_ignored", {31'd0, ir_valid}, 32'd0);
        fetch("reboot", 32'hBFC00000, 32'h24090005, 1);
        check_eq("reboot_opcode", 32'(opcode), 32'h09);
        check_eq("reboot_rt", 32'(rt), 32'd9);
        check_eq("reboot_imm", 32'(imm), 32'h0005);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
